// File: rtl/byte_striping_n_if.sv
// Striping bus between a word producer and the byte_striping_n lane fan-out.
//   valid_in    : data_in carries a word this cycle
//   data_in     : input word (WIDTH bits)
//   lane_cnt_m1 : active lanes minus one, applied at group boundaries
//   flush       : close a partially filled group
//   lane_data   : LANES packed lane registers, lane k at [k*WIDTH +: WIDTH]
//   lane_valid  : one-hot marker of the lane written on the previous edge
//   lane_ptr    : lane the next accepted word will target
//   group_done  : one-cycle pulse when a group closes
//   word_count  : accepted words, modulo 2^16
// master modport: producer side; slave modport: the striping block.
interface byte_striping_n_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
);
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned CW = 16;

  logic                   valid_in;
  logic [WIDTH-1:0]       data_in;
  logic [LW-1:0]          lane_cnt_m1;
  logic                   flush;
  logic [LANES*WIDTH-1:0] lane_data;
  logic [LANES-1:0]       lane_valid;
  logic [LW-1:0]          lane_ptr;
  logic                   group_done;
  logic [CW-1:0]          word_count;

  modport master (
    output valid_in, data_in, lane_cnt_m1, flush,
    input  lane_data, lane_valid, lane_ptr, group_done, word_count
  );

  modport slave (
    input  valid_in, data_in, lane_cnt_m1, flush,
    output lane_data, lane_valid, lane_ptr, group_done, word_count
  );
endinterface

// File: rtl/byte_striping_n.sv
// Round-robin word striper: each accepted word lands in the lane named by
// lane_ptr; the lane pointer wraps after (lane_cnt_m1+1) words or on flush.
// The lane count is sampled only at a group boundary so a mode change never
// splits a group.
//   clk_2f  : clock, all state on rising edge
//   reset_L : asynchronous active-low reset
//   bus     : byte_striping_n_if slave modport (inputs and registered outputs)
module byte_striping_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  byte_striping_n_if.slave  bus
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned CW = 16;

  // Only power-of-two lane counts from 2 to 8 are supported.
  generate
    if (LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
      $error("byte_striping_n: LANES must be 2, 4 or 8");
    end
  endgenerate

  // Registered state
  logic [LANES*WIDTH-1:0] lane_data_q,  lane_data_d;
  logic [LANES-1:0]       lane_valid_q, lane_valid_d;
  logic [LW-1:0]          lane_ptr_q,   lane_ptr_d;
  logic                   group_done_q, group_done_d;
  logic [CW-1:0]          word_count_q, word_count_d;
  logic [LW-1:0]          cur_cfg_q,    cur_cfg_d;

  // Combinational helpers
  logic [LW-1:0]          cfg_c;
  logic                   last_c;

  // State register
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      lane_data_q  <= '0;
      lane_valid_q <= '0;
      lane_ptr_q   <= '0;
      group_done_q <= 1'b0;
      word_count_q <= '0;
      cur_cfg_q    <= '0;
    end else begin
      lane_data_q  <= lane_data_d;
      lane_valid_q <= lane_valid_d;
      lane_ptr_q   <= lane_ptr_d;
      group_done_q <= group_done_d;
      word_count_q <= word_count_d;
      cur_cfg_q    <= cur_cfg_d;
    end
  end

  // Next-state: lane write, pointer advance, group close
  always_comb begin
    // At a group boundary the live lane count is used, otherwise the one
    // captured when the group opened.
    cfg_c  = (lane_ptr_q == '0) ? bus.lane_cnt_m1 : cur_cfg_q;
    last_c = (lane_ptr_q == cfg_c);

    lane_data_d  = lane_data_q;
    lane_valid_d = '0;
    lane_ptr_d   = lane_ptr_q;
    group_done_d = 1'b0;
    word_count_d = word_count_q;
    cur_cfg_d    = cfg_c;

    if (bus.valid_in) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_ptr_q == LW'(k)) begin
          lane_data_d[k*WIDTH +: WIDTH] = bus.data_in;
          lane_valid_d[k]               = 1'b1;
        end
      end
      word_count_d = word_count_q + CW'(1);
      // Flush with a word closes the group after that word is placed.
      if (last_c || bus.flush) begin
        lane_ptr_d   = '0;
        group_done_d = 1'b1;
      end else begin
        lane_ptr_d = lane_ptr_q + LW'(1);
      end
    end else if (bus.flush && (lane_ptr_q != '0)) begin
      lane_ptr_d   = '0;
      group_done_d = 1'b1;
    end
  end

  assign bus.lane_data  = lane_data_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.lane_ptr   = lane_ptr_q;
  assign bus.group_done = group_done_q;
  assign bus.word_count = word_count_q;

  // At most one lane is marked written per cycle.
  a_valid_onehot: assert property (
    @(posedge clk_2f) disable iff (!reset_L) $onehot0(lane_valid_q)
  );

  // Inside a group the pointer never passes the latched lane count.
  a_ptr_in_group: assert property (
    @(posedge clk_2f) disable iff (!reset_L)
      (lane_ptr_q == '0) || (lane_ptr_q <= cur_cfg_q)
  );

endmodule

// File: tb/tb_byte_striping_n.sv
module tb_byte_striping_n;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned LW    = 2;

  logic clk_2f;
  logic reset_L;

  byte_striping_n_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  byte_striping_n #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  int checks;
  int failures;

  // Reference model: group position and size as plain integers.
  logic [WIDTH-1:0] m_lanes [LANES];
  int               m_pos;
  int               m_gsize;
  int               m_count;
  logic [LANES-1:0] m_valid;
  logic             m_done;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [1:0]  cfg;
    logic        fl;
    logic [3:0]  e_valid;
    logic [1:0]  e_ptr;
    logic        e_done;
    int          e_count;
    int          e_lane;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic v, logic [31:0] d, logic [1:0] cfg, logic fl,
                              logic [3:0] ev, logic [1:0] ep, logic ed, int ec,
                              int el, logic [31:0] edata);
    vec_t r;
    r.v = v; r.d = d; r.cfg = cfg; r.fl = fl;
    r.e_valid = ev; r.e_ptr = ep; r.e_done = ed; r.e_count = ec;
    r.e_lane = el; r.e_data = edata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < LANES; k++) m_lanes[k] = '0;
    m_pos = 0; m_gsize = 1; m_count = 0; m_valid = '0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d,
                            input logic [1:0] cfg, input logic fl);
    if (m_pos == 0) m_gsize = int'(cfg) + 1;
    m_valid = '0;
    m_done  = 1'b0;
    if (v) begin
      m_lanes[m_pos] = d;
      m_valid[m_pos] = 1'b1;
      m_count = (m_count + 1) % 65536;
      m_pos++;
      if (m_pos == m_gsize || fl) begin
        m_pos  = 0;
        m_done = 1'b1;
      end
    end else if (fl && m_pos != 0) begin
      m_pos  = 0;
      m_done = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [LANES*WIDTH-1:0] exp_data;
    for (int k = 0; k < LANES; k++) exp_data[k*WIDTH +: WIDTH] = m_lanes[k];
    chk({tag, ".lane_data"},  128'(bus.lane_data),  128'(exp_data));
    chk({tag, ".lane_valid"}, 128'(bus.lane_valid), 128'(m_valid));
    chk({tag, ".lane_ptr"},   128'(bus.lane_ptr),   128'(m_pos));
    chk({tag, ".group_done"}, 128'(bus.group_done), 128'(m_done));
    chk({tag, ".word_count"}, 128'(bus.word_count), 128'(m_count));
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input logic v, input logic [31:0] d,
                       input logic [1:0] cfg, input logic fl);
    bus.valid_in = v; bus.data_in = d; bus.lane_cnt_m1 = cfg; bus.flush = fl;
    model_step(v, d, cfg, fl);
    @(posedge clk_2f);
    #1;
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    bus.valid_in = 1'b0; bus.flush = 1'b0;
    model_reset();
    @(posedge clk_2f); @(posedge clk_2f);
    #1;
    reset_L = 1'b1;
  endtask

  int n_done;
  logic [31:0] rd;
  logic [1:0]  rc;

  initial begin
    checks = 0; failures = 0;
    reset_L = 1'b0;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.lane_cnt_m1 = 2'd3; bus.flush = 1'b0;
    model_reset();

    tbl[0]  = mk(1, 32'hFFFFFFFF, 3, 0, 4'b0001, 1, 0, 1,  0, 32'hFFFFFFFF);
    tbl[1]  = mk(1, 32'hEEEEEEEE, 3, 0, 4'b0010, 2, 0, 2,  1, 32'hEEEEEEEE);
    tbl[2]  = mk(1, 32'hDDDDDDDD, 3, 0, 4'b0100, 3, 0, 3,  2, 32'hDDDDDDDD);
    tbl[3]  = mk(1, 32'hCCCCCCCC, 3, 0, 4'b1000, 0, 1, 4,  3, 32'hCCCCCCCC);
    tbl[4]  = mk(1, 32'h00000003, 3, 0, 4'b0001, 1, 0, 5,  0, 32'h00000003);
    tbl[5]  = mk(0, 32'hBBBBBBBB, 3, 0, 4'b0000, 1, 0, 5,  1, 32'hEEEEEEEE);
    tbl[6]  = mk(0, 32'hAAAAAAAA, 3, 0, 4'b0000, 1, 0, 5,  1, 32'hEEEEEEEE);
    tbl[7]  = mk(1, 32'h00000004, 3, 0, 4'b0010, 2, 0, 6,  1, 32'h00000004);
    tbl[8]  = mk(1, 32'h00000011, 1, 0, 4'b0100, 3, 0, 7,  2, 32'h00000011);
    tbl[9]  = mk(1, 32'h00000022, 1, 0, 4'b1000, 0, 1, 8,  3, 32'h00000022);
    tbl[10] = mk(1, 32'h00000033, 1, 0, 4'b0001, 1, 0, 9,  0, 32'h00000033);
    tbl[11] = mk(1, 32'h00000044, 1, 0, 4'b0010, 0, 1, 10, 1, 32'h00000044);
    tbl[12] = mk(1, 32'h00000055, 1, 0, 4'b0001, 1, 0, 11, 0, 32'h00000055);
    tbl[13] = mk(1, 32'h00000066, 1, 0, 4'b0010, 0, 1, 12, 1, 32'h00000066);
    tbl[14] = mk(1, 32'h00000077, 3, 0, 4'b0001, 1, 0, 13, 0, 32'h00000077);
    tbl[15] = mk(1, 32'h00000088, 3, 0, 4'b0010, 2, 0, 14, 1, 32'h00000088);
    tbl[16] = mk(0, 32'h00000000, 3, 1, 4'b0000, 0, 1, 14, 2, 32'h00000011);
    tbl[17] = mk(1, 32'h00000099, 3, 0, 4'b0001, 1, 0, 15, 0, 32'h00000099);
    tbl[18] = mk(1, 32'h000000AA, 3, 1, 4'b0010, 0, 1, 16, 1, 32'h000000AA);
    tbl[19] = mk(0, 32'h00000000, 3, 1, 4'b0000, 0, 0, 16, 3, 32'h00000022);
    tbl[20] = mk(1, 32'h000000B1, 0, 0, 4'b0001, 0, 1, 17, 0, 32'h000000B1);
    tbl[21] = mk(1, 32'h000000B2, 0, 0, 4'b0001, 0, 1, 18, 0, 32'h000000B2);
    tbl[22] = mk(0, 32'h00000000, 3, 0, 4'b0000, 0, 0, 18, 0, 32'h000000B2);

    // Reset state
    #3;
    chk("rst.lane_data",  128'(bus.lane_data),  128'(0));
    chk("rst.lane_valid", 128'(bus.lane_valid), 128'(0));
    chk("rst.lane_ptr",   128'(bus.lane_ptr),   128'(0));
    chk("rst.group_done", 128'(bus.group_done), 128'(0));
    chk("rst.word_count", 128'(bus.word_count), 128'(0));
    apply_reset();

    // Directed vector table
    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].cfg, tbl[i].fl);
      chk($sformatf("vec%0d.lane_valid", i), 128'(bus.lane_valid), 128'(tbl[i].e_valid));
      chk($sformatf("vec%0d.lane_ptr", i),   128'(bus.lane_ptr),   128'(tbl[i].e_ptr));
      chk($sformatf("vec%0d.group_done", i), 128'(bus.group_done), 128'(tbl[i].e_done));
      chk($sformatf("vec%0d.word_count", i), 128'(bus.word_count), 128'(tbl[i].e_count));
      chk($sformatf("vec%0d.lane_data", i),
          128'(bus.lane_data[tbl[i].e_lane*WIDTH +: WIDTH]), 128'(tbl[i].e_data));
      check_model($sformatf("vec%0d", i));
    end

    // Reset pulsed between edges mid-group with lane_ptr=3
    cycle(1, 32'h12345678, 3, 0);
    cycle(1, 32'h23456789, 3, 0);
    cycle(1, 32'h3456789A, 3, 0);
    chk("midrst.pre_ptr", 128'(bus.lane_ptr), 128'(3));
    bus.valid_in = 1'b0;
    reset_L = 1'b0;
    #1;
    chk("midrst.lane_data",  128'(bus.lane_data),  128'(0));
    chk("midrst.lane_valid", 128'(bus.lane_valid), 128'(0));
    chk("midrst.lane_ptr",   128'(bus.lane_ptr),   128'(0));
    chk("midrst.group_done", 128'(bus.group_done), 128'(0));
    chk("midrst.word_count", 128'(bus.word_count), 128'(0));
    #1;
    reset_L = 1'b1;
    model_reset();
    cycle(1, 32'h0BADF00D, 3, 0);
    check_model("midrst.next");
    chk("midrst.next_lane0", 128'(bus.lane_valid), 128'(4'b0001));

    // Randomized traffic against the model
    rc = 2'd3;
    for (int i = 0; i < 2000; i++) begin
      rd = $urandom;
      if ($urandom_range(0, 15) == 0) rc = 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 9) < 7), rd, rc, ($urandom_range(0, 9) == 0));
      check_model("rand");
    end

    // 65536 accepted words with 4-lane groups
    apply_reset();
    n_done = 0;
    bus.lane_cnt_m1 = 2'd3; bus.flush = 1'b0; bus.valid_in = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      bus.data_in = 32'(i);
      @(posedge clk_2f);
      #1;
      if (bus.group_done) n_done++;
    end
    bus.valid_in = 1'b0;
    chk("wrap.word_count", 128'(bus.word_count), 128'(0));
    chk("wrap.group_done_pulses", 128'(n_done), 128'(16384));
    chk("wrap.lane_ptr", 128'(bus.lane_ptr), 128'(0));
    chk("wrap.lane3", 128'(bus.lane_data[3*WIDTH +: WIDTH]), 128'(32'd65535));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_striping_n.md
BYTE_STRIPING_N -- requirements
Module: byte_striping_n

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each input word and each lane.
REQ-002 Parameter LANES, default 4: number of physical output lanes; legal values are 2, 4 and 8.
REQ-003 Derived constant LW = log2(LANES): bit width of the lane pointer and the lane-count configuration.
REQ-004 Port clk_2f, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port valid_in, input, 1 bit: data_in carries a word to stripe this cycle.
REQ-007 Port data_in, input, WIDTH bits: input word.
REQ-008 Port lane_cnt_m1, input, LW bits: number of active lanes minus one (runtime mode select).
REQ-009 Port flush, input, 1 bit: closes a partial group.
REQ-010 Port lane_data, output, LANES*WIDTH bits: lane k occupies bits [k*WIDTH +: WIDTH].
REQ-011 Port lane_valid, output, LANES bits: one-hot pulse marking the lane written in the previous edge.
REQ-012 Port lane_ptr, output, LW bits: lane that the next accepted word will target.
REQ-013 Port group_done, output, 1 bit: one-cycle pulse when a group closes.
REQ-014 Port word_count, output, 16 bits: count of accepted words, wrapping modulo 2^16.

Function
REQ-015 The block SHALL accept a word on each rising edge where valid_in=1; no backpressure, one word per cycle maximum.
REQ-016 An accepted word SHALL be registered into lane_data[lane_ptr], with lane_valid[lane_ptr]=1 the following cycle (latency 1).
REQ-017 lane_valid SHALL be all-zero in any cycle following an edge with valid_in=0.
REQ-018 Unwritten lanes SHALL hold their previous lane_data value.
REQ-019 Effective configuration cfg = lane_cnt_m1 when lane_ptr=0, else the internally latched cur_cfg.
REQ-020 cur_cfg SHALL be reloaded with cfg on every edge, so a lane_cnt_m1 change takes effect only at a group boundary (lane_ptr=0).
REQ-021 On an accepted word, lane_ptr SHALL advance to 0 if lane_ptr=cfg, else to lane_ptr+1.
REQ-022 On an accepted word, group_done SHALL pulse when lane_ptr=cfg.
REQ-023 Invalid cycles (valid_in=0) SHALL NOT advance lane_ptr, word_count or the group.
REQ-024 flush=1 with lane_ptr≠0: lane_ptr SHALL go to 0 next edge and group_done SHALL pulse; lanes beyond the last written lane SHALL receive no lane_valid.
REQ-025 flush=1 with valid_in=1: the word SHALL be accepted at the current lane_ptr first, then lane_ptr SHALL be set to 0 and group_done SHALL pulse.
REQ-026 flush=1 with lane_ptr=0 and valid_in=0: no-op; group_done stays 0.
REQ-027 lane_cnt_m1=0 SHALL place every word on lane 0, with group_done pulsing on each accepted word.
REQ-028 word_count SHALL increment by 1 per accepted word and wrap from 16'hFFFF to 0.

Reset
REQ-029 While reset_L=0, the following SHALL be 0 asynchronously: lane_data, lane_valid, lane_ptr, group_done, word_count and cur_cfg.
REQ-030 After reset_L deasserts, the first accepted word SHALL go to lane 0 with cfg taken from lane_cnt_m1.
REQ-031 Reset asserted mid-group SHALL discard the partial group; no group_done SHALL be issued for it.

Verification
REQ-032 LANES=4, lane_cnt_m1=3, words FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC back-to-back -> the words appear on lanes 0..3; lane_valid = 0001, 0010, 0100, 1000; group_done on the 4th word; word_count=4.
REQ-033 valid pattern 1,0,0,1 with data 3, BBBBBBBB, AAAAAAAA, 4 -> lane0=3, lane1=4; lane_ptr=2; the invalid data is never written.
REQ-034 lane_cnt_m1 changed from 3 to 1 while lane_ptr=2 -> the group completes on lanes 2 and 3, then subsequent words alternate lanes 0 and 1 only.
REQ-035 Two words accepted, then flush=1 with valid_in=0 -> group_done=1, lane_ptr=0, and the next word goes to lane 0; flush together with a valid word at lane_ptr=1 -> the word lands on lane 1, then lane_ptr=0.
REQ-036 reset_L pulsed low between edges while lane_ptr=3 -> all outputs read 0 immediately, and the next word goes to lane 0.
REQ-037 65536 accepted words -> word_count=0, and group_done has pulsed 16384 times with LANES=4 and lane_cnt_m1=3.
